hdmi_fb_read_arbiter: RTL

Shares the single read port of the HDMI capture framebuffer (`hdmi_framebuffer`) between two requesters: port 0, the real-time display scanner, and port 1, the host/SPI readback path. It accepts coordinate requests through a valid/ack handshake and drives the framebuffer read address. It also tracks the in-flight reads through the fixed RAM read latency and returns each pixel to the requester that issued it. Out-of-window coordinates are answered with black and do not touch the RAM address.

---
 rtl/hdmi_fb_read_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hdmi_fb_read_arbiter.sv
// Two-port read arbiter for the HDMI capture framebuffer: port 0 (display scanner) over port 1 (host readback).
// Optional starvation guard for port 1 enabled by defining FB_ARB_STARVE_EN.
module hdmi_fb_read_arbiter #(
  parameter int unsigned WIDTH        = 128,
  parameter int unsigned HEIGHT       = 100,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [11:0] x0,
  input  logic [11:0] y0,
  output logic        ack0,
  output logic        rvalid0,
  output logic [23:0] rgb0,
  input  logic        req1,
  input  logic [11:0] x1,
  input  logic [11:0] y1,
  output logic        ack1,
  output logic        rvalid1,
  output logic [23:0] rgb1,
  output logic [11:0] fb_xaddr,
  output logic [11:0] fb_yaddr,
  input  logic [7:0]  fb_r,
  input  logic [7:0]  fb_g,
  input  logic [7:0]  fb_b
);

  localparam int unsigned CW  = 12;
  localparam int unsigned PW  = 24;
  localparam int unsigned LAT = (RD_LATENCY < 1) ? 1 : ((RD_LATENCY > 4) ? 4 : RD_LATENCY);

  // Out-of-range parameters leave a named marker block in the elaborated hierarchy.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_starve_limit_out_of_range
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_rd_latency_out_of_range
  end

  logic          starve;
  logic          gnt;
  logic          gnt_port;
  logic          gnt_oob;
  logic [CW-1:0] gnt_x;
  logic [CW-1:0] gnt_y;

  logic [LAT-1:0] trk_v;
  logic [LAT-1:0] trk_p;
  logic [LAT-1:0] trk_o;
  logic           tail_v;
  logic           tail_p;
  logic           tail_o;
  logic [PW-1:0]  ret_rgb;

`ifdef FB_ARB_STARVE_EN
  localparam logic [7:0] STARVE_THR = (STARVE_LIMIT < 1) ? 8'd1 :
                                      ((STARVE_LIMIT > 255) ? 8'd255 : 8'(STARVE_LIMIT));
  logic [7:0] starve_cnt;

  // Count cycles port 1 waits; saturates, clears once served or when it withdraws.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 8'd0;
    end else if (!req1 || ack1) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign starve = req1 & (starve_cnt >= STARVE_THR);
`else
  assign starve = 1'b0;
`endif

  // Fixed-priority grant; a starving port 1 inverts priority for a single cycle.
  always_comb begin
    ack0     = 1'b0;
    ack1     = 1'b0;
    if (reset_n) begin
      ack0 = req0 & ~starve;
      ack1 = req1 & (~req0 | starve);
    end
    gnt      = ack0 | ack1;
    gnt_port = ack1;
    gnt_x    = ack1 ? x1 : x0;
    gnt_y    = ack1 ? y1 : y0;
    gnt_oob  = (32'(gnt_x) >= WIDTH) || (32'(gnt_y) >= HEIGHT);
  end

  // Address stage: only in-window grants move the RAM address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_xaddr <= '0;
      fb_yaddr <= '0;
    end else if (gnt && !gnt_oob) begin
      fb_xaddr <= gnt_x;
      fb_yaddr <= gnt_y;
    end
  end

  // Tracking stage 0 is written at the grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_v[0] <= 1'b0;
      trk_p[0] <= 1'b0;
      trk_o[0] <= 1'b0;
    end else begin
      trk_v[0] <= gnt;
      trk_p[0] <= gnt_port;
      trk_o[0] <= gnt_oob;
    end
  end

  // Remaining stages follow the RAM read latency.
  for (genvar i = 1; i < LAT; i++) begin : g_trk
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        trk_v[i] <= 1'b0;
        trk_p[i] <= 1'b0;
        trk_o[i] <= 1'b0;
      end else begin
        trk_v[i] <= trk_v[i-1];
        trk_p[i] <= trk_p[i-1];
        trk_o[i] <= trk_o[i-1];
      end
    end
  end

  assign tail_v  = trk_v[LAT-1];
  assign tail_p  = trk_p[LAT-1];
  assign tail_o  = trk_o[LAT-1];
  assign ret_rgb = tail_o ? '0 : {fb_r, fb_g, fb_b};

  // Return stage: steer the pixel to the port that issued it; OOB reads return black.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rgb0    <= '0;
      rgb1    <= '0;
    end else begin
      rvalid0 <= tail_v & ~tail_p;
      rvalid1 <= tail_v & tail_p;
      if (tail_v && !tail_p) begin
        rgb0 <= ret_rgb;
      end
      if (tail_v && tail_p) begin
        rgb1 <= ret_rgb;
      end
    end
  end

endmodule
